// File: rtl/ball_ctrl.sv
// Projectile controller: launches a ball from its owner, flies it along x,
// deals a single damage pulse on contact, then plays a hit animation and cooldown.
module ball_ctrl #(
  parameter int SPEED       = 6,
  parameter int BALL_DAMAGE = 20,
  parameter int COOLDOWN    = 120,
  parameter int HIT_FRAMES  = 8,
  parameter int HIT_W       = 32,
  parameter int HIT_H       = 48,
  parameter int SPAWN_DX    = 40,
  parameter int SPAWN_DY    = 20,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 600
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       active,
  input  logic       summon_ball,
  input  logic       owner_face,
  input  logic [9:0] owner_x,
  input  logic [9:0] owner_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  output logic       ball_ready,
  output logic       ball_on,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [2:0] ball_frame,
  output logic [9:0] damage
);

  localparam int CW = $clog2(COOLDOWN + 1);

  typedef enum logic [1:0] {
    READY = 2'd0,
    FLY   = 2'd1,
    HIT   = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t          state_r;
  logic            dir_r;
  logic [CW-1:0]   cool_cnt_r;

  logic [10:0]     spawn_right_s;
  logic [10:0]     spawn_left_s;
  logic [9:0]      spawn_x_s;
  logic [9:0]      dx_s;
  logic [9:0]      dy_s;
  logic            overlap_s;
  logic [11:0]     next_x_s;
  logic            out_of_bounds_s;

  assign ball_ready = (state_r == READY) && active;
  assign ball_on    = (state_r == FLY) || (state_r == HIT);

  // Spawn position, overlap test and next flight step, all without wraparound
  always_comb begin
    spawn_right_s = {1'b0, owner_x} + 11'(SPAWN_DX);
    if (spawn_right_s > 11'(X_MAX)) begin
      spawn_right_s = 11'(X_MAX);
    end else begin
      spawn_right_s = spawn_right_s;
    end

    // A left spawn below X_MIN (including negative) clamps to X_MIN
    if ({1'b0, owner_x} < 11'(SPAWN_DX + X_MIN)) begin
      spawn_left_s = 11'(X_MIN);
    end else begin
      spawn_left_s = {1'b0, owner_x} - 11'(SPAWN_DX);
    end

    if (owner_face) begin
      spawn_x_s = spawn_left_s[9:0];
    end else begin
      spawn_x_s = spawn_right_s[9:0];
    end

    if (ball_x >= target_x) begin
      dx_s = ball_x - target_x;
    end else begin
      dx_s = target_x - ball_x;
    end
    if (ball_y >= target_y) begin
      dy_s = ball_y - target_y;
    end else begin
      dy_s = target_y - ball_y;
    end
    overlap_s = (dx_s < 10'(HIT_W)) && (dy_s < 10'(HIT_H));

    if (dir_r) begin
      next_x_s = {2'b00, ball_x} - 12'(SPEED);
    end else begin
      next_x_s = {2'b00, ball_x} + 12'(SPEED);
    end
    out_of_bounds_s = next_x_s[11] || (next_x_s < 12'(X_MIN)) || (next_x_s > 12'(X_MAX));
  end

  // Ball state machine; everything freezes while active is low
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= READY;
      dir_r      <= 1'b0;
      cool_cnt_r <= '0;
      ball_x     <= 10'd0;
      ball_y     <= 10'd0;
      ball_frame <= 3'd0;
      damage     <= 10'd0;
    end else begin
      damage <= 10'd0;
      if (active) begin
        case (state_r)
          READY: begin
            if (summon_ball) begin
              state_r <= FLY;
              dir_r   <= owner_face;
              ball_x  <= spawn_x_s;
              ball_y  <= owner_y + 10'(SPAWN_DY);
            end
          end
          FLY: begin
            // Contact wins over leaving the field in the same frame
            if (overlap_s) begin
              state_r    <= HIT;
              damage     <= 10'(BALL_DAMAGE);
              ball_frame <= 3'd0;
            end else if (out_of_bounds_s) begin
              state_r    <= COOL;
              cool_cnt_r <= CW'(COOLDOWN - 1);
            end else begin
              ball_x <= next_x_s[9:0];
            end
          end
          HIT: begin
            if (ball_frame == 3'(HIT_FRAMES - 1)) begin
              state_r    <= COOL;
              ball_frame <= 3'd0;
              cool_cnt_r <= CW'(COOLDOWN - 1);
            end else begin
              ball_frame <= ball_frame + 3'd1;
            end
          end
          COOL: begin
            if (cool_cnt_r == '0) begin
              state_r <= READY;
            end else begin
              cool_cnt_r <= cool_cnt_r - CW'(1);
            end
          end
          default: state_r <= READY;
        endcase
      end
    end
  end

endmodule
